uart_tx_frame: RTL and testbench

UART transmit framer: the transmit end of the team's UART link, and the counterpart of the oversampling receive path. It accepts one parallel byte per handshake and shifts out a start bit, 8 data bits LSB-first, an optional parity bit and one stop bit on `Tx_Out`. Bit timing comes from the same `Prescale` (clocks per bit) used on the receive side, so both directions share one clock and one prescale setting.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_parity_calc.sv | 18 +
 rtl/uart_tx_frame.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and prescale limits.
// Both the transmit framer and the receive path import this package.
package uart_pkg;

  // Frame sequencing states, shared by the transmit and receive FSMs.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity type selector values.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Shortest legal bit period in clocks; smaller prescale requests are clamped up to this.
  localparam logic [5:0] MIN_PRESCALE = 6'd4;

  // Bit period actually used for a given prescale request.
  function automatic logic [5:0] eff_prescale(input logic [5:0] prescale);
    return (prescale < MIN_PRESCALE) ? MIN_PRESCALE : prescale;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: even or odd parity over one payload word.
// The receive-side parity checker uses the same block.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par
);

  // Even parity makes the total count of ones even; odd parity inverts that bit.
  always_comb begin
    o_par = (^i_data) ^ (i_par_typ == PAR_ODD);
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB-first, optional parity bit,
// one stop bit. Bit timing is eff_prescale clocks per bit; outputs are registered.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic [5:0]            Prescale,
  output logic                  Tx_Out,
  output logic                  Busy
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           r_state;
  uart_state_e           w_state_next;

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [5:0]            r_prescale;
  logic [5:0]            r_edge_cnt;
  logic [BitCntW-1:0]    r_bit_cnt;
  logic                  r_tx;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_bit_end;
  logic                  w_last_bit;
  logic                  w_parity;
  logic                  w_tx_next;

  // Requests are only taken in IDLE, which also guarantees one idle cycle between frames.
  assign w_accept   = (r_state == IDLE) && Data_Valid;
  // r_prescale is at least MIN_PRESCALE outside IDLE, so the subtraction never wraps there.
  assign w_bit_end  = (r_edge_cnt == (r_prescale - 6'd1));
  assign w_last_bit = (r_bit_cnt == BitCntW'(DATA_WIDTH - 1));

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (r_data),
    .i_par_typ(r_par_typ),
    .o_par    (w_parity)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the line level for the current state.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = 1'b1;
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (Data_Valid) begin
          w_state_next = START;
        end
      end
      START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        w_tx_next = r_shreg[0];
        if (w_bit_end && w_last_bit) begin
          w_state_next = r_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        w_tx_next = w_parity;
        if (w_bit_end) begin
          w_state_next = STOP;
        end
      end
      STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // Edge counter: position within the current bit period, held at 0 while idle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_edge_cnt <= 6'd0;
    end else if ((r_state == IDLE) || w_bit_end) begin
      r_edge_cnt <= 6'd0;
    end else begin
      r_edge_cnt <= r_edge_cnt + 6'd1;
    end
  end

  // Bit counter: index of the data bit on the line, only advances during DATA.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_bit_cnt <= '0;
    end else if (r_state != DATA) begin
      r_bit_cnt <= '0;
    end else if (w_bit_end) begin
      r_bit_cnt <= w_last_bit ? '0 : (r_bit_cnt + 1'b1);
    end
  end

  // Frame capture at acceptance; the shift copy moves right once per data bit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_data     <= '0;
      r_shreg    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= PAR_EVEN;
      r_prescale <= 6'd0;
    end else if (w_accept) begin
      r_data     <= P_Data;
      r_shreg    <= P_Data;
      r_par_en   <= Par_En;
      r_par_typ  <= Par_Typ;
      r_prescale <= eff_prescale(Prescale);
    end else if ((r_state == DATA) && w_bit_end) begin
      r_shreg    <= r_shreg >> 1;
    end
  end

  // Registered outputs: the line follows the state one cycle later, Busy covers the frame.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= (r_state != IDLE);
    end
  end

  assign Tx_Out = r_tx;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: expected frames are queued when requests are
// driven and compared cycle by cycle against Tx_Out/Busy when the start bit is due.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic       pe  = 1'b0;
  logic       pt  = 1'b0;
  logic [7:0] pd  = 8'h00;
  logic [5:0] ps  = 6'd8;
  logic       tx;
  logic       busy;

  uart_tx_frame #(
    .DATA_WIDTH(8)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .P_Data    (pd),
    .Data_Valid(dv),
    .Par_En    (pe),
    .Par_Typ   (pt),
    .Prescale  (ps),
    .Tx_Out    (tx),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    int unsigned eff;
    int unsigned start;
  } frame_t;

  frame_t      q[$];
  frame_t      cur;
  int          n_total = 0;
  int          n_bad   = 0;
  bit          mon_en  = 1'b0;
  bit          in_frame = 1'b0;
  int unsigned k = 0;
  int unsigned frames_done = 0;
  int unsigned frames_sent = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned eff_of(input logic [5:0] p);
    return (p < 6'd4) ? 4 : int'(p);
  endfunction

  function automatic int unsigned len_of(input frame_t f);
    return (10 + (f.pe ? 1 : 0)) * f.eff;
  endfunction

  // Line level expected k cycles into frame f.
  function automatic logic exp_level(input frame_t f, input int unsigned kk);
    int unsigned b;
    b = kk / f.eff;
    if (b == 0) return 1'b0;
    if (b <= 8) return f.data[b-1];
    if ((b == 9) && f.pe) return (^f.data) ^ f.pt;
    return 1'b1;
  endfunction

  // Monitor/scoreboard: idle checks between frames, per-cycle checks inside a frame.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!in_frame && (q.size() > 0) && (cyc > q[0].start)) begin
        chk("late_start", cyc, q[0].start);
        void'(q.pop_front());
        frames_done++;
      end
      if (!in_frame && (q.size() > 0) && (cyc == q[0].start)) begin
        cur      = q.pop_front();
        in_frame = 1'b1;
        k        = 0;
      end
      if (in_frame) begin
        if (k < len_of(cur)) begin
          chk($sformatf("tx_%02h_k%0d", cur.data, k), tx, exp_level(cur, k));
          chk($sformatf("busy_%02h_k%0d", cur.data, k), busy, 1);
          k++;
        end else begin
          chk($sformatf("end_busy_%02h", cur.data), busy, 0);
          chk($sformatf("end_tx_%02h", cur.data), tx, 1);
          in_frame = 1'b0;
          frames_done++;
        end
      end else begin
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);
      end
    end
  end

  // Drive one request at a negedge; acceptance is the next posedge, start bit one cycle later.
  task automatic send(input logic [7:0] d, input logic pe_i, input logic pt_i,
                      input logic [5:0] ps_i, input bit hold, input bit push,
                      output int unsigned start);
    frame_t f;
    pd = d;
    pe = pe_i;
    pt = pt_i;
    ps = ps_i;
    dv = 1'b1;
    f.data  = d;
    f.pe    = pe_i;
    f.pt    = pt_i;
    f.eff   = eff_of(ps_i);
    f.start = cyc + 2;
    start   = f.start;
    if (push) begin
      q.push_back(f);
      frames_sent++;
    end
    @(negedge clk);
    if (!hold) dv = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while ((frames_done < frames_sent) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < frames_sent) chk("timeout", frames_done, frames_sent);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int unsigned s;
    int unsigned s2;
    frame_t f2;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);

    // Plain frame, no parity.
    send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1, s);
    wait_done(300);

    // Even then odd parity over two ones.
    send(8'h03, 1'b1, 1'b0, 6'd16, 1'b0, 1'b1, s);
    wait_done(400);
    send(8'h03, 1'b1, 1'b1, 6'd16, 1'b0, 1'b1, s);
    wait_done(400);

    // Back-to-back with Data_Valid held; inputs changed while busy.
    send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b1, 1'b1, s);
    f2.data  = 8'h5A;
    f2.pe    = 1'b0;
    f2.pt    = 1'b0;
    f2.eff   = 8;
    f2.start = s + 80 + 1;
    s2       = f2.start;
    q.push_back(f2);
    frames_sent++;
    repeat (20) @(negedge clk);
    pd = 8'h5A;
    while (cyc < s2 - 1) @(negedge clk);
    dv = 1'b0;
    pd = 8'hFF;
    pe = 1'b1;
    pt = 1'b1;
    ps = 6'd4;
    wait_done(400);

    // Reset during the third data bit aborts the frame.
    mon_en = 1'b0;
    send(8'h5A, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, s);
    while (cyc < s + 8 * 3 + 2) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    chk("abort_pre_bit2", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    send(8'h3C, 1'b1, 1'b1, 6'd8, 1'b0, 1'b1, s);
    wait_done(300);

    // Request coinciding with reset is dropped.
    rst = 1'b1;
    dv  = 1'b1;
    pd  = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    dv  = 1'b0;
    chk("rst_dv_busy", busy, 0);
    repeat (20) @(negedge clk);

    // Prescale clamp and maximum prescale.
    send(8'hC3, 1'b1, 1'b0, 6'd2, 1'b0, 1'b1, s);
    wait_done(200);
    send(8'h81, 1'b0, 1'b0, 6'd63, 1'b0, 1'b1, s);
    wait_done(1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
